// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared processor types.
//   word_t      - 32-bit machine word
//   ramstate_t  - RAM status reported back to the memory controller
//   arb_state_t - mem_arbiter FSM states, exported so benches can name them
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IGRANT = 2'd1,
        DGRANT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: request-unit side and RAM side of the memory arbiter.
//   requester -> arb : iREN, iaddr, dREN, dWEN, daddr, dstore
//   RAM       -> arb : ramstate, ramload
//   arb -> RAM       : ramREN, ramWEN, ramaddr, ramstore
//   arb -> requester : ihit, dhit, iload, dload
// Modports: arb (the arbiter), tb (whatever drives/observes it).
interface mem_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    ramstate_t ramstate;
    word_t     ramload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    logic      ihit;
    logic      dhit;
    word_t     iload;
    word_t     dload;

    modport arb (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        output ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
        input  ramREN, ramWEN, ramaddr, ramstore, ihit, dhit, iload, dload
    );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data.
// Data wins arbitration unless the instruction side has lost STARVE_LIMIT
// consecutive contested arbitrations. Each grant is held until RAM reports
// ACCESS (hit) or ERROR (drop, requester retries), then one IDLE cycle.
// Ports:
//   CLK  - clock, rising edge
//   nRST - asynchronous active-low reset
//   bus  - mem_arbiter_if.arb (request, RAM and completion signals)
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          nRST,
    mem_arbiter_if.arb    bus
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          dreq;
    logic          ram_done;

    assign dreq     = bus.dREN | bus.dWEN;
    // ACCESS and ERROR both end the grant; only ACCESS produces a hit.
    assign ram_done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq && bus.iREN)
                    state_d = (starve_q == STARVE_MAX) ? IGRANT : DGRANT;
                else if (dreq)
                    state_d = DGRANT;
                else if (bus.iREN)
                    state_d = IGRANT;
            end
            IGRANT:  if (ram_done || !bus.iREN) state_d = IDLE;
            DGRANT:  if (ram_done || !dreq)     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counts contested data wins; any cycle without a fetch request resets it.
    always_comb begin
        starve_d = starve_q;
        if (!bus.iREN)
            starve_d = '0;
        else if (state_q == IDLE && state_d == IGRANT)
            starve_d = '0;
        else if (state_q == IDLE && state_d == DGRANT && starve_q != STARVE_MAX)
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // RAM side is Moore on state; hit/load additionally follow ramstate.
    // Data read/write type tracks the live dWEN.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.ihit     = 1'b0;
        bus.dhit     = 1'b0;
        bus.iload    = '0;
        bus.dload    = '0;
        case (state_q)
            IGRANT: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                if (bus.ramstate == ACCESS) begin
                    bus.ihit  = 1'b1;
                    bus.iload = bus.ramload;
                end
            end
            DGRANT: begin
                bus.ramWEN   = bus.dWEN;
                bus.ramREN   = ~bus.dWEN;
                bus.ramstore = bus.dWEN ? bus.dstore : '0;
                bus.ramaddr  = bus.daddr;
                if (bus.ramstate == ACCESS) begin
                    bus.dhit  = 1'b1;
                    bus.dload = bus.ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: every ACCESS the bench drives pushes the
// expected completion {side, data}; a negedge monitor pops and compares when
// ihit/dhit appear, and flags any hit nothing was expected for.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    typedef struct packed {
        logic  d;
        word_t v;
    } exp_t;

    logic CLK;
    logic nRST;
    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.arb)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h @%0t", tag, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Drive ACCESS for the current grant and expect the matching hit.
    task automatic ram_done(input logic d, input word_t v);
        bus.ramstate = ACCESS;
        bus.ramload  = v;
        sb.push_back({d, v});
        #1;
        if (d) chk("dhit", 32'(bus.dhit), 32'd1);
        else   chk("ihit", 32'(bus.ihit), 32'd1);
        cyc();
        bus.ramstate = FREE;
        bus.ramload  = '0;
    endtask

    always @(negedge CLK) begin
        exp_t e;
        if (nRST) begin
            chk("hit_excl", 32'(bus.ihit & bus.dhit), 32'd0);
            chk("en_excl", 32'(bus.ramREN & bus.ramWEN), 32'd0);
            if (!bus.ihit) chk("iload_zero", bus.iload, 32'd0);
            if (!bus.dhit) chk("dload_zero", bus.dload, 32'd0);
            if (bus.ihit || bus.dhit) begin
                if (sb.size() == 0) begin
                    chk("unexp_hit", 32'({bus.ihit, bus.dhit}), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("hit_side", 32'(bus.dhit), 32'(e.d));
                    chk("hit_data", e.d ? bus.dload : bus.iload, e.v);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        nRST = 1'b0;
        bus.iREN = 0; bus.iaddr = '0; bus.dREN = 0; bus.dWEN = 0;
        bus.daddr = '0; bus.dstore = '0; bus.ramstate = FREE; bus.ramload = '0;
        cyc(); cyc();
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        chk("rst_starve", 32'(dut.starve_q), 32'd0);
        chk("rst_outs", 32'({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit}), 32'd0);
        nRST = 1'b1;

        // Instruction read, RAM busy two cycles.
        bus.iREN = 1; bus.iaddr = 32'h100;
        #1 chk("i_idle_ren", 32'(bus.ramREN), 32'd0);
        cyc();
        bus.ramstate = BUSY;
        #1 chk("i_ren", 32'(bus.ramREN), 32'd1);
        chk("i_addr", bus.ramaddr, 32'h100);
        chk("i_busy_nohit", 32'(bus.ihit), 32'd0);
        cyc();
        ram_done(1'b0, 32'hDEADBEEF);
        bus.iREN = 0;
        #1 chk("i_bubble", 32'(dut.state_q), 32'(IDLE));
        chk("i_bubble_ren", 32'(bus.ramREN), 32'd0);

        // Contested: data write first, one bubble, then fetch.
        bus.iREN = 1; bus.iaddr = 32'h180;
        bus.dWEN = 1; bus.daddr = 32'h200; bus.dstore = 32'h1234;
        cyc();
        chk("c_state", 32'(dut.state_q), 32'(DGRANT));
        chk("c_wen", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
        chk("c_addr", bus.ramaddr, 32'h200);
        chk("c_store", bus.ramstore, 32'h1234);
        ram_done(1'b1, 32'h0000_0042);
        bus.dWEN = 0;
        #1 chk("c_bubble", 32'(dut.state_q), 32'(IDLE));
        cyc();
        chk("c_igrant", 32'(dut.state_q), 32'(IGRANT));
        chk("c_iaddr", bus.ramaddr, 32'h180);
        ram_done(1'b0, 32'h1111_2222);

        // Starvation guard: 4 data wins, then fetch, then data again.
        bus.dREN = 1; bus.daddr = 32'h240;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("s_dgrant", 32'(dut.state_q), 32'(DGRANT));
            chk("s_count", 32'(dut.starve_q), 32'(k + 1));
            ram_done(1'b1, 32'hD0 + 32'(k));
        end
        cyc();
        chk("s_igrant", 32'(dut.state_q), 32'(IGRANT));
        chk("s_clear", 32'(dut.starve_q), 32'd0);
        ram_done(1'b0, 32'h5151);
        cyc();
        chk("s_resume", 32'(dut.state_q), 32'(DGRANT));
        chk("s_count1", 32'(dut.starve_q), 32'd1);
        ram_done(1'b1, 32'hD9);
        bus.iREN = 0; bus.dREN = 0;

        // RAM error during fetch: drop, then retry.
        bus.iREN = 1; bus.iaddr = 32'h300;
        cyc();
        bus.ramstate = ERROR;
        #1 chk("e_nohit", 32'(bus.ihit), 32'd0);
        cyc();
        bus.ramstate = FREE;
        chk("e_idle", 32'(dut.state_q), 32'(IDLE));
        cyc();
        chk("e_regrant", 32'(dut.state_q), 32'(IGRANT));
        ram_done(1'b0, 32'hCAFEF00D);
        bus.iREN = 0;

        // dREN+dWEN is a write; live dWEN flips type; dropping dREN aborts.
        bus.dREN = 1; bus.dWEN = 1; bus.daddr = 32'h400; bus.dstore = 32'h55;
        cyc();
        bus.ramstate = BUSY;
        #1 chk("w_both", 32'({bus.ramWEN, bus.ramREN}), 32'b10);
        chk("w_store", bus.ramstore, 32'h55);
        bus.dWEN = 0;
        #1 chk("w_live_rd", 32'({bus.ramWEN, bus.ramREN}), 32'b01);
        chk("w_rd_store", bus.ramstore, 32'd0);
        cyc();
        bus.dREN = 0;
        cyc();
        chk("w_abort", 32'(dut.state_q), 32'(IDLE));
        bus.ramstate = FREE;

        // Reset mid-DGRANT with RAM busy.
        bus.dREN = 1; bus.daddr = 32'h500;
        cyc();
        bus.ramstate = BUSY;
        #1 chk("r_ren", 32'(bus.ramREN), 32'd1);
        nRST = 0;
        #1 chk("r_outs", 32'({bus.ramREN, bus.ramWEN, bus.dhit}), 32'd0);
        chk("r_addr", bus.ramaddr, 32'd0);
        chk("r_state", 32'(dut.state_q), 32'(IDLE));
        bus.dREN = 0; bus.ramstate = ACCESS;
        cyc();
        nRST = 1;
        cyc(); cyc();
        chk("r_after", 32'(dut.state_q), 32'(IDLE));
        bus.ramstate = FREE;
        cyc();

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction-fetch requester and the data requester; both are driven by the request unit.
- Each transaction is granted to one requester, held until RAM completes or faults, then completion is signalled.
- Data has priority over instruction, with a starvation guard so fetch always progresses.
- Sits between the request unit and the RAM model, inside the memory-control level of the processor.

Parameters:
- STARVE_LIMIT, 4: number of consecutive data grants, while an instruction request is pending, after which the instruction side wins the next arbitration.

Ports:
- CLK  input  1  system clock; rising edge
- nRST  input  1  asynchronous active-low reset
- iREN  input  1  instruction read request; level, held until ihit
- iaddr  input  32  instruction address (word_t)
- dREN  input  1  data read request; level
- dWEN  input  1  data write request; level; wins over dREN if both are high
- daddr  input  32  data address (word_t)
- dstore  input  32  data write value (word_t)
- ramstate  input  2  RAM status (ramstate_t): FREE, BUSY, ACCESS, ERROR
- ramload  input  32  RAM read data (word_t)
- ramREN  output  1  RAM read enable
- ramWEN  output  1  RAM write enable
- ramaddr  output  32  RAM address
- ramstore  output  32  RAM write data
- ihit  output  1  instruction transaction complete; one cycle
- dhit  output  1  data transaction complete; one cycle
- iload  output  32  instruction read data; valid when ihit
- dload  output  32  data read data; valid when dhit

Behaviour:
- FSM state_t states: IDLE, IGRANT, DGRANT.
- Outputs are Moore on state, except hit/load, which also depend on ramstate.
- Reset (async, nRST=0): state=IDLE, starve counter=0. All outputs 0 while in IDLE with no hit.
- Reset mid-transaction aborts the transaction; no hit is produced.

IDLE:
- No RAM enables.
- Arbitration uses registered requests:
  - dreq = dREN|dWEN.
  - If dreq and iREN are both high: IGRANT if starve==STARVE_LIMIT, else DGRANT.
  - If only one is high: grant that side.
  - If neither: stay in IDLE.
- The decision takes one cycle, so RAM enables first appear the cycle after a request is seen in IDLE.

IGRANT:
- Drives ramREN=1, ramWEN=0, ramaddr=iaddr.
- ramstate==ACCESS: ihit=1 and iload=ramload in the same cycle; next state IDLE.
- ramstate==ERROR: next state IDLE, no hit; the request stays high and is retried.
- iREN dropped: next state IDLE, no hit.
- Otherwise (FREE/BUSY): hold.

DGRANT:
- If dWEN: ramWEN=1, ramREN=0, ramstore=dstore. Else: ramREN=1.
- ramaddr=daddr.
- ACCESS: dhit=1, dload=ramload; next state IDLE.
- ERROR, or dREN and dWEN both low: next state IDLE, no hit.
- Read/write type follows the live dWEN each cycle.

General rules:
- Every completion is followed by one IDLE bubble cycle; there are no back-to-back grants.
- iload/dload are 0 whenever the matching hit is 0.
- ihit and dhit are never high in the same cycle.
- RAM enables are never both high.

Starve counter:
- Width $clog2(STARVE_LIMIT+1).
- On IDLE→DGRANT with iREN=1: increment, saturating at STARVE_LIMIT.
- On IDLE→IGRANT, or any cycle with iREN=0: clear to 0.

Decomposition:
- Use word_t, ramstate_t and its encodings (FREE, BUSY, ACCESS, ERROR) from cpu_types_pkg.
- Add arb_state_t (IDLE, IGRANT, DGRANT) to cpu_types_pkg for visibility in benches.
- Add mem_arbiter_if with modports arb and tb to the include directory, matching the existing interface style.
- No sub-module; the starve counter is inline.

Test Plan:
- Reset during DGRANT with RAM BUSY → outputs 0 immediately; state IDLE; no dhit after release.
- iREN=1, iaddr=0x100, RAM BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF → ramREN high from cycle 1; ihit=1 and iload=0xDEADBEEF on the ACCESS cycle; IDLE next cycle.
- iREN and dWEN both asserted, daddr=0x200, dstore=0x1234 → DGRANT first, with ramWEN=1, ramaddr=0x200, ramstore=0x1234 and dhit on ACCESS; then one IDLE cycle; then IGRANT.
- iREN held with dREN held, STARVE_LIMIT=4 → exactly 4 dhits, then an ihit, then data resumes; the counter is observed clearing after the ihit.
- ramstate=ERROR during IGRANT → no ihit; IDLE next cycle; a re-grant to the still-pending iREN completes normally.
- dREN and dWEN both high → treated as a write; dREN dropped mid-DGRANT → IDLE next cycle with no dhit.
